// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes RV32I ALU-relevant fields into a 4-bit ALU control
// code and operand B selection, then holds the decoded entry for the EX stage
// in an output register with a one-deep skid register behind it. A
// valid/ready handshake on both sides guarantees FIFO order with no drops or
// duplicates. Unsupported encodings are flagged and counted.
module alu_issue_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic                  funct7b5,
  input  logic [DATA_WIDTH-1:0] rs1_val,
  input  logic [DATA_WIDTH-1:0] rs2_val,
  input  logic [DATA_WIDTH-1:0] imm,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3:0]            ALUctl,
  output logic [DATA_WIDTH-1:0] A,
  output logic [DATA_WIDTH-1:0] B,
  output logic                  is_branch,
  output logic [2:0]            br_funct3,
  output logic                  illegal,
  output logic [CNT_WIDTH-1:0]  illegal_cnt
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] CTL_AND = 4'b0000;
  localparam logic [3:0] CTL_OR  = 4'b0001;
  localparam logic [3:0] CTL_ADD = 4'b0010;
  localparam logic [3:0] CTL_SUB = 4'b0110;
  localparam logic [3:0] CTL_SLT = 4'b0111;
  localparam logic [3:0] CTL_BAD = 4'b1111;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [3:0]            aluctl;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic                  is_branch;
    logic [2:0]            br_funct3;
    logic                  illegal;
  } entry_t;

  entry_t dec;
  entry_t out_q;
  entry_t skid_q;
  logic   out_valid_q;
  logic   skid_valid_q;
  logic   accept;
  logic   retire;

  // Decode the offered instruction into an EX entry.
  always_comb begin
    // NOTE: every field gets a default before the case so no path can leave
    // a field unassigned and infer a latch.
    dec           = '0;
    dec.a         = rs1_val;
    dec.b         = rs2_val;
    dec.aluctl    = CTL_BAD;
    dec.illegal   = 1'b1;
    case (opcode)
      OP_R, OP_I: begin
        dec.illegal = 1'b0;
        if (opcode == OP_I) dec.b = imm;
        case (funct3)
          3'b000:  dec.aluctl = (opcode == OP_R && funct7b5) ? CTL_SUB : CTL_ADD;
          3'b111:  dec.aluctl = CTL_AND;
          3'b110:  dec.aluctl = CTL_OR;
          3'b010:  dec.aluctl = CTL_SLT;
          default: begin
            dec.aluctl  = CTL_BAD;
            dec.illegal = 1'b1;
            dec.b       = rs2_val;
          end
        endcase
      end
      OP_LOAD, OP_STORE: begin
        dec.aluctl  = CTL_ADD;
        dec.b       = imm;
        dec.illegal = 1'b0;
      end
      OP_BRANCH: begin
        if (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b100) begin
          dec.aluctl    = (funct3 == 3'b100) ? CTL_SLT : CTL_SUB;
          dec.illegal   = 1'b0;
          dec.is_branch = 1'b1;
          dec.br_funct3 = funct3;
        end
      end
      default: ;
    endcase
  end

  assign in_ready = ~skid_valid_q;
  assign accept   = in_valid & in_ready & ~flush;
  assign retire   = out_valid_q & out_ready;

  // Output register and skid register; flush outranks accept and retire.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      // NOTE: the data registers are reset too, because the reset values of
      // ALUctl/A/B are visible on the outputs.
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (!out_valid_q || retire) begin
      if (skid_valid_q) begin
        out_q        <= skid_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
      end else if (accept) begin
        out_q       <= dec;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (accept) begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      skid_q       <= dec;
      skid_valid_q <= 1'b1;
    end
  end

  // Saturating count of accepted illegal entries; only reset clears it.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      illegal_cnt <= '0;
    end else if (accept && dec.illegal && illegal_cnt != CNT_MAX) begin
      illegal_cnt <= illegal_cnt + 1'b1;
    end
  end

  assign out_valid = out_valid_q;
  assign ALUctl    = out_q.aluctl;
  assign A         = out_q.a;
  assign B         = out_q.b;
  assign is_branch = out_q.is_branch;
  assign br_funct3 = out_q.br_funct3;
  assign illegal   = out_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: the driver pushes a hand-computed
// expected entry on every accept, and a monitor pops and compares on every
// retire. A second instance with CNT_WIDTH=2 shares the stimulus to exercise
// counter saturation.
module tb_alu_issue_stage;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  opcode = '0;
  logic [2:0]  funct3 = '0;
  logic        funct7b5 = 1'b0;
  logic [31:0] rs1_val = '0;
  logic [31:0] rs2_val = '0;
  logic [31:0] imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [3:0]  ALUctl;
  logic [31:0] A;
  logic [31:0] B;
  logic        is_branch;
  logic [2:0]  br_funct3;
  logic        illegal;
  logic [15:0] illegal_cnt;

  logic        s_in_ready, s_out_valid, s_is_branch, s_illegal;
  logic [3:0]  s_aluctl;
  logic [31:0] s_a, s_b;
  logic [2:0]  s_br_funct3;
  logic [1:0]  s_illegal_cnt;

  int checks = 0;
  int failures = 0;
  logic [79:0] sb[$];

  always #5 clock = ~clock;

  alu_issue_stage #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clock(clock), .resetn(resetn), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm), .out_valid(out_valid),
    .out_ready(out_ready), .ALUctl(ALUctl), .A(A), .B(B), .is_branch(is_branch),
    .br_funct3(br_funct3), .illegal(illegal), .illegal_cnt(illegal_cnt)
  );

  alu_issue_stage #(.DATA_WIDTH(32), .CNT_WIDTH(2)) dut_small (
    .clock(clock), .resetn(resetn), .flush(flush), .in_valid(in_valid),
    .in_ready(s_in_ready), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm), .out_valid(s_out_valid),
    .out_ready(out_ready), .ALUctl(s_aluctl), .A(s_a), .B(s_b),
    .is_branch(s_is_branch), .br_funct3(s_br_funct3), .illegal(s_illegal),
    .illegal_cnt(s_illegal_cnt)
  );

  function automatic logic [79:0] pk(input logic [3:0] ctl, input logic [31:0] a,
                                     input logic [31:0] b, input logic br,
                                     input logic [2:0] f3, input logic ill);
    return {7'b0, ctl, a, b, br, f3, ill};
  endfunction

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: compare every retiring entry against the scoreboard head.
  initial begin
    logic [79:0] exp;
    forever begin
      @(negedge clock);
      #2;
      if (resetn && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual=%h required=none",
                   pk(ALUctl, A, B, is_branch, br_funct3, illegal));
        end else begin
          exp = sb.pop_front();
          check("retired_entry", pk(ALUctl, A, B, is_branch, br_funct3, illegal), exp);
        end
      end
    end
  end

  // Offer one instruction and push its expected entry when it is accepted.
  task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                      input logic [31:0] r1, input logic [31:0] r2,
                      input logic [31:0] im, input logic [79:0] exp);
    int n = 0;
    @(negedge clock);
    in_valid = 1'b1; opcode = op; funct3 = f3; funct7b5 = f7;
    rs1_val = r1; rs2_val = r2; imm = im;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clock);
      #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=in_ready_low required=accept");
      in_valid = 1'b0;
    end else begin
      sb.push_back(exp);
      @(posedge clock);
    end
  endtask

  task automatic idle();
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    idle();
    while (sb.size() != 0 && n < 30) begin
      @(negedge clock);
      n++;
    end
    #3;
    check(name, 80'(sb.size()), 80'd0);
  endtask

  initial begin
    // Reset state.
    #12;
    check("reset_out_valid", 80'(out_valid), 80'd0);
    check("reset_in_ready", 80'(in_ready), 80'd1);
    check("reset_entry", pk(ALUctl, A, B, is_branch, br_funct3, illegal), 80'd0);
    check("reset_cnt", 80'(illegal_cnt), 80'd0);
    @(negedge clock);
    resetn = 1'b1;

    // R-type back-to-back, rs1=7, rs2=5.
    send(7'b0110011, 3'b000, 1'b0, 32'd7, 32'd5, 32'd0, pk(4'b0010, 32'd7, 32'd5, 1'b0, 3'b000, 1'b0));
    send(7'b0110011, 3'b000, 1'b1, 32'd7, 32'd5, 32'd0, pk(4'b0110, 32'd7, 32'd5, 1'b0, 3'b000, 1'b0));
    send(7'b0110011, 3'b010, 1'b0, 32'd7, 32'd5, 32'd0, pk(4'b0111, 32'd7, 32'd5, 1'b0, 3'b000, 1'b0));
    send(7'b0110011, 3'b111, 1'b0, 32'd7, 32'd5, 32'd0, pk(4'b0000, 32'd7, 32'd5, 1'b0, 3'b000, 1'b0));
    send(7'b0110011, 3'b110, 1'b0, 32'd7, 32'd5, 32'd0, pk(4'b0001, 32'd7, 32'd5, 1'b0, 3'b000, 1'b0));
    drain("drain_rtype");

    // addi with negative imm (funct7b5 ignored), lw, blt.
    send(7'b0010011, 3'b000, 1'b1, 32'd7, 32'd9, 32'hFFFF_FFFD, pk(4'b0010, 32'd7, 32'hFFFF_FFFD, 1'b0, 3'b000, 1'b0));
    send(7'b0000011, 3'b010, 1'b0, 32'd100, 32'd9, 32'd16, pk(4'b0010, 32'd100, 32'd16, 1'b0, 3'b000, 1'b0));
    send(7'b1100011, 3'b100, 1'b0, 32'd3, 32'd9, 32'd40, pk(4'b0111, 32'd3, 32'd9, 1'b1, 3'b100, 1'b0));
    send(7'b0100011, 3'b010, 1'b0, 32'd8, 32'd1, 32'd4, pk(4'b0010, 32'd8, 32'd4, 1'b0, 3'b000, 1'b0));
    send(7'b1100011, 3'b001, 1'b0, 32'd2, 32'd6, 32'd0, pk(4'b0110, 32'd2, 32'd6, 1'b1, 3'b001, 1'b0));
    drain("drain_imm_branch");

    // Stream of 4 with out_ready low for 3 cycles starting at the 2nd.
    fork
      begin
        send(7'b0110011, 3'b000, 1'b0, 32'd1, 32'd10, 32'd0, pk(4'b0010, 32'd1, 32'd10, 1'b0, 3'b000, 1'b0));
        send(7'b0110011, 3'b000, 1'b0, 32'd2, 32'd20, 32'd0, pk(4'b0010, 32'd2, 32'd20, 1'b0, 3'b000, 1'b0));
        send(7'b0110011, 3'b000, 1'b0, 32'd3, 32'd30, 32'd0, pk(4'b0010, 32'd3, 32'd30, 1'b0, 3'b000, 1'b0));
        send(7'b0110011, 3'b000, 1'b0, 32'd4, 32'd40, 32'd0, pk(4'b0010, 32'd4, 32'd40, 1'b0, 3'b000, 1'b0));
      end
      begin
        @(negedge clock);
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        @(negedge clock);
        #1;
        check("stall_in_ready_low", 80'(in_ready), 80'd0);
        @(negedge clock);
        @(negedge clock);
        out_ready = 1'b1;
      end
    join
    drain("drain_stall");

    // Illegal encodings: SYSTEM opcode, then R-type f3=001.
    send(7'b1110011, 3'b000, 1'b0, 32'd5, 32'd6, 32'd7, pk(4'b1111, 32'd5, 32'd6, 1'b0, 3'b000, 1'b1));
    #2;
    check("cnt_after_1", 80'(illegal_cnt), 80'd1);
    send(7'b0110011, 3'b001, 1'b0, 32'd5, 32'd6, 32'd7, pk(4'b1111, 32'd5, 32'd6, 1'b0, 3'b000, 1'b1));
    drain("drain_illegal");
    check("cnt_after_2", 80'(illegal_cnt), 80'd2);

    // Flush with both entries full and an illegal offer in the same cycle.
    out_ready = 1'b0;
    send(7'b0110011, 3'b111, 1'b0, 32'hA, 32'hB, 32'd0, pk(4'b0000, 32'hA, 32'hB, 1'b0, 3'b000, 1'b0));
    send(7'b0110011, 3'b110, 1'b0, 32'hC, 32'hD, 32'd0, pk(4'b0001, 32'hC, 32'hD, 1'b0, 3'b000, 1'b0));
    @(negedge clock);
    flush = 1'b1; in_valid = 1'b1; opcode = 7'b1110011; funct3 = 3'b000;
    rs1_val = 32'hDEAD; rs2_val = 32'hBEEF;
    @(negedge clock);
    flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    #1;
    check("flush_out_valid", 80'(out_valid), 80'd0);
    check("flush_in_ready", 80'(in_ready), 80'd1);
    check("flush_cnt_unchanged", 80'(illegal_cnt), 80'd2);
    out_ready = 1'b1;
    repeat (4) @(negedge clock);

    // Three more illegals: 5 in total, 2-bit counter holds 3.
    for (int i = 0; i < 3; i++)
      send(7'b1100011, 3'b010, 1'b0, 32'(i), 32'd1, 32'd0, pk(4'b1111, 32'(i), 32'd1, 1'b0, 3'b000, 1'b1));
    drain("drain_saturate");
    check("cnt_main_5", 80'(illegal_cnt), 80'd5);
    check("cnt_small_sat", 80'(s_illegal_cnt), 80'd3);

    // Asynchronous reset mid-stall.
    out_ready = 1'b0;
    send(7'b0110011, 3'b000, 1'b0, 32'd11, 32'd12, 32'd0, pk(4'b0010, 32'd11, 32'd12, 1'b0, 3'b000, 1'b0));
    send(7'b0110011, 3'b000, 1'b1, 32'd13, 32'd14, 32'd0, pk(4'b0110, 32'd13, 32'd14, 1'b0, 3'b000, 1'b0));
    idle();
    #3;
    resetn = 1'b0;
    #1;
    sb.delete();
    check("async_out_valid", 80'(out_valid), 80'd0);
    check("async_in_ready", 80'(in_ready), 80'd1);
    check("async_entry", pk(ALUctl, A, B, is_branch, br_funct3, illegal), 80'd0);
    check("async_cnt", 80'(illegal_cnt), 80'd0);
    check("async_cnt_small", 80'(s_illegal_cnt), 80'd0);
    @(negedge clock);
    resetn = 1'b1;
    out_ready = 1'b1;
    send(7'b0010011, 3'b111, 1'b0, 32'hF0, 32'd1, 32'h3C, pk(4'b0000, 32'hF0, 32'h3C, 1'b0, 3'b000, 1'b0));
    drain("drain_after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Producer end of the ALU control interface: decodes RV32I opcode/funct fields into the 4-bit ALU control code and selects operand B.
- Registers {ALUctl, A, B, branch info} into the EX stage.
- Sits between the ID stage and the ALU. Uses a valid/ready handshake with a 2-entry skid buffer so ALU-side stalls never drop or duplicate instructions.
- Flags unsupported encodings and counts them.

Parameters:
DATA_WIDTH  32  operand width (A, B, imm)
CNT_WIDTH   16  width of saturating illegal-instruction counter

Ports:
clock        input   1           rising-edge clock
resetn       input   1           asynchronous active-low reset
flush        input   1           synchronous flush of both buffered entries
in_valid     input   1           ID offers an instruction
in_ready     output  1           stage can accept this cycle
opcode       input   7           instr[6:0]
funct3       input   3           instr[14:12]
funct7b5     input   1           instr[30]
rs1_val      input   DATA_WIDTH  operand A source
rs2_val      input   DATA_WIDTH  operand B source (register)
imm          input   DATA_WIDTH  pre-generated sign-extended immediate
out_valid    output  1           EX entry valid
out_ready    input   1           EX/ALU consumes entry this cycle
ALUctl       output  4           ALU control code
A            output  DATA_WIDTH  ALU operand A
B            output  DATA_WIDTH  ALU operand B
is_branch    output  1           entry is a conditional branch
br_funct3    output  3           branch funct3 passthrough (zero when not a branch)
illegal      output  1           entry is an unsupported encoding
illegal_cnt  output  CNT_WIDTH   saturating count of illegal entries accepted

Behaviour:
- Reset (resetn low, async): out_valid=0, in_ready=1, ALUctl=0000, A=B=0, is_branch=0, br_funct3=0, illegal=0, illegal_cnt=0, skid empty.
- Decode (combinational on inputs, captured when accepted):
  - R-type 0110011:
    - f3=000: ADD 0010 if funct7b5=0, SUB 0110 if 1.
    - f3=111: AND 0000. f3=110: OR 0001. f3=010: SLT 0111.
    - B=rs2_val.
  - I-arith 0010011:
    - f3=000: ADD 0010. f3=111: AND 0000. f3=110: OR 0001. f3=010: SLT 0111.
    - B=imm; funct7b5 ignored.
  - Load 0000011 / store 0100011: ADD 0010, B=imm.
  - Branch 1100011:
    - f3=000 or 001: SUB 0110. f3=100: SLT 0111.
    - B=rs2_val, is_branch=1, br_funct3=funct3.
  - Any other opcode or funct3: ALUctl=1111, illegal=1, B=rs2_val, is_branch=0.
  - A=rs1_val always. Code 1100 (NOR) is never generated.
- Handshake:
  - Accept when in_valid & in_ready; retire when out_valid & out_ready.
  - Latency 1: an entry accepted at edge N appears on the outputs after edge N when the output register is empty or retiring.
- Skid buffer:
  - Output register plus one skid register.
  - If an accept occurs while the output register holds a non-retiring entry, the new entry goes to the skid register.
  - in_ready is registered: in_ready = skid empty.
  - When the output register retires and skid is full, skid moves to output, skid empties, and in_ready returns to 1 next cycle.
  - Accept and retire in the same cycle with skid empty: the new entry replaces the output directly (throughput 1/cycle).
- Ordering: strict FIFO. No entry is dropped or duplicated.
- Flush:
  - Priority over accept and retire in the same cycle.
  - Next cycle: out_valid=0, skid empty, in_ready=1. Data outputs keep stale values.
  - An input offered during the flush cycle is not accepted, and illegal_cnt does not count it.
- illegal_cnt:
  - Increments by 1 on each accepted entry with illegal=1.
  - Saturates at 2^CNT_WIDTH-1.
  - Unaffected by flush; cleared only by reset.
- Reset asserted mid-operation discards all entries immediately (async).

Test Plan:
- add x, sub, slt, and, or R-type with rs1=7, rs2=5, out_ready=1 -> ALUctl 0010/0110/0111/0000/0001, A=7, B=5, one cycle after each accept, back-to-back.
- addi imm=-3 (0xFFFFFFFD), rs2_val=9; then lw; then blt f3=100 -> B=0xFFFFFFFD with ALUctl 0010; B=imm with ALUctl 0010; ALUctl 0111 with is_branch=1, br_funct3=100.
- Stream of 4 instructions with out_ready low for 3 cycles from the 2nd -> in_ready drops after the skid fills; all 4 emerge in order with no loss or duplication once out_ready=1.
- flush asserted with both entries full and in_valid=1 in the same cycle -> next cycle out_valid=0, in_ready=1; the offered instruction does not appear later.
- opcode 1110011, then R-type f3=001 -> ALUctl=1111, illegal=1, illegal_cnt 0->1->2. With CNT_WIDTH=2 forced, 5 illegals -> cnt holds 3.
- resetn pulsed low asynchronously mid-stall (not on a clock edge) -> outputs take reset values immediately; normal operation resumes after release.
